// File: rtl/ahfp_lzd_pipe.sv
// ahfp_lzd_pipe: pipelined leading-zero counter / leading-one locator for the ahfp normaliser.
// Latency: exactly PIPE_STAGES cycles from input transfer to out_valid; one result per cycle.
// Backpressure: elastic valid/ready stages with bubble collapse; in_ready falls only when every stage is full and out_ready is low.
// Optional: define AHFP_LZD_NORM_EN to add out_norm (in_data shifted so its leading one sits at bit WIDTH-1).
module ahfp_lzd_pipe #(
    parameter int WIDTH       = 48,
    parameter int PIPE_STAGES = 2,
    localparam int CW         = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_lzc,
    output logic [CW-1:0]    out_pos,
`ifdef AHFP_LZD_NORM_EN
    output logic [WIDTH-1:0] out_norm,
`endif
    output logic             out_zero
);

    // Padded width: next power of two (at least one 4-bit leaf); the pad sits below the LSB.
    localparam int PW   = (WIDTH <= 4) ? 4 : (1 << $clog2(WIDTH));
    localparam int NL   = PW / 4;
    localparam int LV   = $clog2(NL);
    localparam int PL   = $clog2(PW);
    localparam int OFF  = PW - WIDTH;
    localparam int LAST = PIPE_STAGES - 1;

    logic [PW-1:0]                        pad;
    logic [NL-1:0]                        leaf_v;
    logic [NL-1:0][PL-1:0]                leaf_p;
    logic [PIPE_STAGES-1:0][NL-1:0]       src_v;
    logic [PIPE_STAGES-1:0][NL-1:0][PL-1:0] src_p;
`ifdef AHFP_LZD_NORM_EN
    logic [PIPE_STAGES-1:0][WIDTH-1:0]    src_d;
    logic [WIDTH-1:0]                     norm_q;
`endif
    logic [PIPE_STAGES-1:0]               v_q, v_d, load, sv, en;
    logic [CW-1:0]                        lzc_q, pos_q;
    logic                                 zero_q;

    // Left-align the input in the padded vector; pad zeros sit below any real bit so cannot win.
    always_comb begin
        pad = '0;
        pad[PW-1 -: WIDTH] = in_data;
    end

    // Leaf priority encoders: per nibble, any-set flag and index of its highest set bit.
    always_comb begin
        leaf_v = '0;
        leaf_p = '0;
        for (int j = 0; j < NL; j++) begin
            leaf_v[j] = |pad[4*j +: 4];
            if (pad[4*j+3])      leaf_p[j] = PL'(3);
            else if (pad[4*j+2]) leaf_p[j] = PL'(2);
            else if (pad[4*j+1]) leaf_p[j] = PL'(1);
            else                 leaf_p[j] = PL'(0);
        end
    end

    assign src_v[0] = leaf_v;
    assign src_p[0] = leaf_p;
`ifdef AHFP_LZD_NORM_EN
    assign src_d[0] = in_data;
`endif

    // Ready ripples from the output back: a stage can load if it is empty or everything ahead can move.
    always_comb begin : ready_chain
        logic rdy_dn;
        load   = '0;
        rdy_dn = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            load[k] = ~v_q[k] | rdy_dn;
            rdy_dn  = load[k];
        end
    end

    // Valid feeding each stage: the input for stage 0, the previous stage otherwise.
    assign sv        = PIPE_STAGES'({v_q, in_valid});
    assign en        = load & sv;
    assign v_d       = (load & sv) | (~load & v_q);
    assign in_ready  = ~rst & load[0];
    assign out_valid = v_q[LAST];

    // Stage occupancy flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) v_q <= '0;
        else     v_q <= v_d;
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        // Tree levels 1..LV are shared out across the stages as evenly as integer division allows.
        localparam int LO = (k * LV) / PIPE_STAGES;
        localparam int HI = ((k + 1) * LV) / PIPE_STAGES;

        logic [NL-1:0]         wv, tv;
        logic [NL-1:0][PL-1:0] wp, tp;

        // Pairwise combine: the upper child wins if it holds a one, its index gains the child-span bit.
        always_comb begin
            wv = src_v[k];
            wp = src_p[k];
            tv = '0;
            tp = '0;
            for (int l = 1; l <= LV; l++) begin
                if (l > LO && l <= HI) begin
                    tv = '0;
                    tp = '0;
                    for (int i = 0; i < NL / 2; i++) begin
                        tv[i] = wv[2*i+1] | wv[2*i];
                        tp[i] = wv[2*i+1] ? (wp[2*i+1] | (PL'(1) << (l + 1))) : wp[2*i];
                    end
                    wv = tv;
                    wp = tp;
                end
            end
        end

        if (k < LAST) begin : g_mid
            logic [NL-1:0]         nv_q;
            logic [NL-1:0][PL-1:0] np_q;
`ifdef AHFP_LZD_NORM_EN
            logic [WIDTH-1:0]      nd_q;
`endif
            // Partial tree state captured whenever this stage accepts a new entry.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    nv_q <= '0;
                    np_q <= '0;
`ifdef AHFP_LZD_NORM_EN
                    nd_q <= '0;
`endif
                end else if (en[k]) begin
                    nv_q <= wv;
                    np_q <= wp;
`ifdef AHFP_LZD_NORM_EN
                    nd_q <= src_d[k];
`endif
                end
            end
            assign src_v[k+1] = nv_q;
            assign src_p[k+1] = np_q;
`ifdef AHFP_LZD_NORM_EN
            assign src_d[k+1] = nd_q;
`endif
        end else begin : g_last
            logic [CW-1:0] pos_c, lzc_c;
            logic          zero_c;

            // Map the padded root index back to the real bit index; all-zero gets its own encoding.
            always_comb begin
                zero_c = ~|wv;
                pos_c  = CW'(wp[0]) - CW'(OFF);
                lzc_c  = CW'(WIDTH - 1) - pos_c;
                if (zero_c) begin
                    pos_c = '0;
                    lzc_c = CW'(WIDTH);
                end
            end

            // Result registers; they hold while the output is stalled.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lzc_q  <= '0;
                    pos_q  <= '0;
                    zero_q <= 1'b0;
`ifdef AHFP_LZD_NORM_EN
                    norm_q <= '0;
`endif
                end else if (en[k]) begin
                    lzc_q  <= lzc_c;
                    pos_q  <= pos_c;
                    zero_q <= zero_c;
`ifdef AHFP_LZD_NORM_EN
                    norm_q <= src_d[k] << lzc_c;
`endif
                end
            end
        end
    end

    assign out_lzc  = lzc_q;
    assign out_pos  = pos_q;
    assign out_zero = zero_q;
`ifdef AHFP_LZD_NORM_EN
    assign out_norm = norm_q;
`endif

endmodule

// File: tb/tb_ahfp_lzd_pipe.sv
// Bench for ahfp_lzd_pipe: three configurations (48/2, 5/1, 100/4) against a queue-based reference.
// Inputs are applied at the falling edge; outputs are sampled 1 time unit later.
// The reference tracks accepted items with their acceptance cycle and derives ready/valid from occupancy.
module tb_ahfp_lzd_pipe;

    localparam int WS [3] = '{48, 5, 100};
    localparam int PS [3] = '{2, 1, 4};

    typedef struct packed {
        int           t;
        int           lzc;
        int           pos;
        logic         z;
        logic [127:0] norm;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Stimulus requested by the sequence, and the copies actually driven into the DUTs.
    logic         s_iv [3];
    logic [127:0] s_id [3];
    logic         s_or [3];
    logic         d_iv [3];
    logic [127:0] d_id [3];
    logic         d_or [3];

    logic       ir [3];
    logic       ov [3];
    logic       z  [3];
    logic [5:0] lzc0, pos0;
    logic [2:0] lzc1, pos1;
    logic [6:0] lzc2, pos2;
`ifdef AHFP_LZD_NORM_EN
    logic [47:0] norm0;
    logic [4:0]  norm1;
    logic [99:0] norm2;
`endif

    ent_t mq  [3][8];
    int   hd  [3];
    int   cnt [3];
    logic acc [3];
    int   cyc;
    int   checks;
    int   errors;

    ahfp_lzd_pipe #(.WIDTH(WS[0]), .PIPE_STAGES(PS[0])) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(d_iv[0]), .in_ready(ir[0]), .in_data(d_id[0][47:0]),
        .out_valid(ov[0]), .out_ready(d_or[0]), .out_lzc(lzc0), .out_pos(pos0),
`ifdef AHFP_LZD_NORM_EN
        .out_norm(norm0),
`endif
        .out_zero(z[0]));

    ahfp_lzd_pipe #(.WIDTH(WS[1]), .PIPE_STAGES(PS[1])) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(d_iv[1]), .in_ready(ir[1]), .in_data(d_id[1][4:0]),
        .out_valid(ov[1]), .out_ready(d_or[1]), .out_lzc(lzc1), .out_pos(pos1),
`ifdef AHFP_LZD_NORM_EN
        .out_norm(norm1),
`endif
        .out_zero(z[1]));

    ahfp_lzd_pipe #(.WIDTH(WS[2]), .PIPE_STAGES(PS[2])) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(d_iv[2]), .in_ready(ir[2]), .in_data(d_id[2][99:0]),
        .out_valid(ov[2]), .out_ready(d_or[2]), .out_lzc(lzc2), .out_pos(pos2),
`ifdef AHFP_LZD_NORM_EN
        .out_norm(norm2),
`endif
        .out_zero(z[2]));

    // Reference: scan from the MSB for the first one.
    function automatic ent_t ref_ent(input logic [127:0] d, input int w, input int t);
        ent_t e;
        int   p;
        p = -1;
        for (int i = w - 1; i >= 0; i--)
            if (p < 0 && d[i]) p = i;
        e.t = t;
        if (p < 0) begin
            e.lzc = w; e.pos = 0; e.z = 1'b1; e.norm = '0;
        end else begin
            e.lzc  = w - 1 - p;
            e.pos  = p;
            e.z    = 1'b0;
            e.norm = (d << e.lzc) & ((128'(1) << w) - 128'(1));
        end
        return e;
    endfunction

    function automatic logic [127:0] rnd(input int w);
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        d = d >> (128 - w);
        d = d >> $urandom_range(0, w);
        if ($urandom_range(0, 15) == 0) d = '0;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl(input int id, input logic o_ir, input logic o_ov, input logic [127:0] o_lzc,
                       input logic [127:0] o_pos, input logic o_z, input logic [127:0] o_norm);
        string s;
        logic  e_ir, e_ov;
        ent_t  h;
        s = $sformatf("d%0d(W%0d,P%0d)@%0d", id, WS[id], PS[id], cyc);
        if (rst) begin
            chk({s, " rst in_ready"}, o_ir, 0);
            chk({s, " rst out_valid"}, o_ov, 0);
            chk({s, " rst lzc"}, o_lzc, 0);
            chk({s, " rst pos"}, o_pos, 0);
            chk({s, " rst zero"}, o_z, 0);
`ifdef AHFP_LZD_NORM_EN
            chk({s, " rst norm"}, o_norm, 0);
`endif
            cnt[id] = 0;
            hd[id]  = 0;
            acc[id] = 1'b0;
        end else begin
            e_ir = d_or[id] || (cnt[id] < PS[id]);
            e_ov = (cnt[id] > 0) && (mq[id][hd[id]].t + PS[id] <= cyc);
            chk({s, " in_ready"}, o_ir, e_ir);
            chk({s, " out_valid"}, o_ov, e_ov);
            if (e_ov) begin
                h = mq[id][hd[id]];
                chk({s, " lzc"}, o_lzc, h.lzc);
                chk({s, " pos"}, o_pos, h.pos);
                chk({s, " zero"}, o_z, h.z);
`ifdef AHFP_LZD_NORM_EN
                chk({s, " norm"}, o_norm, h.norm);
`endif
            end
            acc[id] = d_iv[id] && e_ir;
            if (e_ov && d_or[id]) begin
                hd[id]  = (hd[id] + 1) % 8;
                cnt[id] = cnt[id] - 1;
            end
            if (acc[id]) begin
                mq[id][(hd[id] + cnt[id]) % 8] = ref_ent(d_id[id], WS[id], cyc);
                cnt[id] = cnt[id] + 1;
            end
        end
    endtask

    task automatic step(input logic r);
        logic [127:0] n0, n1, n2;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < 3; i++) begin
            d_iv[i] = s_iv[i];
            d_id[i] = s_id[i];
            d_or[i] = s_or[i];
        end
        #1;
        n0 = '0; n1 = '0; n2 = '0;
`ifdef AHFP_LZD_NORM_EN
        n0 = 128'(norm0); n1 = 128'(norm1); n2 = 128'(norm2);
`endif
        mdl(0, ir[0], ov[0], 128'(lzc0), 128'(pos0), z[0], n0);
        mdl(1, ir[1], ov[1], 128'(lzc1), 128'(pos1), z[1], n1);
        mdl(2, ir[2], ov[2], 128'(lzc2), 128'(pos2), z[2], n2);
        cyc++;
    endtask

    task automatic set(input int id, input logic v, input logic [127:0] d, input logic o);
        s_iv[id] = v;
        s_id[id] = d;
        s_or[id] = o;
    endtask

    initial begin
        logic [127:0] va [4];
        logic [127:0] vb [3];
        int           idx;
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int i = 0; i < 3; i++) begin
            set(i, 1'b0, '0, 1'b1);
            d_iv[i] = 1'b0; d_id[i] = '0; d_or[i] = 1'b1;
            hd[i] = 0; cnt[i] = 0; acc[i] = 1'b0;
        end

        // Reset state.
        step(1'b1);
        step(1'b1);

        // Directed single vectors, out_ready held high.
        va = '{128'h800000000000, 128'h000000000001, 128'h0, 128'h000000000F00};
        vb = '{128'b10000, 128'b00001, 128'b00000};
        for (int n = 0; n < 4; n++) begin
            set(0, 1'b1, va[n], 1'b1);
            set(1, n < 3, (n < 3) ? vb[n] : 128'h0, 1'b1);
            step(1'b0);
            set(0, 1'b0, '0, 1'b1);
            set(1, 1'b0, '0, 1'b1);
            step(1'b0);
            step(1'b0);
        end
        for (int n = 0; n < 4; n++) step(1'b0);

        // Back-to-back one-hot inputs with a downstream stall in cycles 2..5.
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            set(0, idx < 6, 128'(1) << idx, !(c >= 2 && c <= 5));
            step(1'b0);
            if (acc[0]) idx++;
        end
        set(0, 1'b0, '0, 1'b1);

        // Reset with results in flight, then a fresh input after release.
        for (int n = 0; n < 2; n++) begin
            set(0, 1'b1, rnd(WS[0]), 1'b0);
            set(2, 1'b1, rnd(WS[2]), 1'b0);
            step(1'b0);
        end
        set(0, 1'b0, '0, 1'b1);
        set(2, 1'b0, '0, 1'b1);
        step(1'b1);
        for (int n = 0; n < 4; n++) step(1'b0);
        set(0, 1'b1, 128'h000000F00000, 1'b1);
        set(2, 1'b1, 128'h1, 1'b1);
        step(1'b0);
        set(0, 1'b0, '0, 1'b1);
        set(2, 1'b0, '0, 1'b1);
        for (int n = 0; n < 6; n++) step(1'b0);

        // Random sweep with random valid and ready on every configuration.
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 3; i++)
                set(i, $urandom_range(0, 3) != 0, rnd(WS[i]), $urandom_range(0, 3) != 0);
            step(1'b0);
        end

        // Drain.
        for (int i = 0; i < 3; i++) set(i, 1'b0, '0, 1'b1);
        for (int n = 0; n < 8; n++) step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
